i2s_clock_gen: RTL and testbench
================================

# i2s_clock_gen

Parametrised, synthesisable serial-clock and word-select generator for the I2S verification environment. It derives SCLK and WS from the single system clock with a programmable divider, word length, channel count and framing mode (I2S, left-justified, TDM/DSP). It replaces the fixed testbench clock/reset stimulus as the timing master that drives the I2S interface for the transmitter and receiver BFMs. It also exports bit/slot position and edge strobes so that data shifters can run synchronously in the `clk` domain.

## Interface
- DIV_W, 8: width of `half_div`.
- BITS_W, 6: width of `word_bits` and `bit_idx`. Word length ranges 8..32.
- CH_W, 3: width of `num_ch_m1` and `chan_idx`. Up to 8 TDM slots.
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level; start/keep generating frames.
- half_div  in  DIV_W  SCLK half-period in `clk` cycles. 0 is treated as 1.
- word_bits  in  BITS_W  bits per slot. <8 clamps to 8; >32 clamps to 32.
- num_ch_m1  in  CH_W  TDM slot count minus 1. Ignored in modes 0/1, which are always 2 channels.
- mode  in  2  0 = I2S, 1 = left-justified, 2 = TDM (DSP-A), 3 = treated as 0.
- sclk  out  1  serial clock. Idles low.
- ws  out  1  word select / frame sync.
- sclk_rise_stb  out  1  1-cycle strobe, coincident with `sclk` 0->1 (sample point).
- sclk_fall_stb  out  1  1-cycle strobe, coincident with `sclk` 1->0 (drive point).
- frame_start  out  1  1-cycle strobe at start of slot 0, bit 0.
- chan_idx  out  CH_W  current slot.
- bit_idx  out  BITS_W  current bit in slot; 0 = MSB.
- busy  out  1  high in RUN and DRAIN.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - Outputs: `sclk`, `ws`, strobes, indices and `busy` are all 0.
  - `enable`=1 -> RUN.
- **Config latch:** `half_div`, `word_bits`, `num_ch_m1` and `mode` are latched on IDLE->RUN and at every frame boundary. Mid-frame changes are ignored.
- **RUN entry cycle:** `chan_idx`=0, `bit_idx`=0, `frame_start`=1, `sclk`=0 (bit period begins low).
- **Divider:** counts 0..half_div-1. At terminal count it toggles `sclk` and asserts the matching strobe in the same cycle.
- **Index advance:** each falling edge increments `bit_idx`. At word_bits-1 it wraps to 0 and increments `chan_idx`. At the last channel's last bit, it wraps to a new frame and asserts `frame_start`.
- **ws, updated on the falling edge with the indices:**
  - Mode 1: `ws` = `chan_idx`[0].
  - Mode 0: `ws` = channel of the next bit period, i.e. it toggles one SCLK before the MSB. Entering RUN: `ws`=0.
  - Mode 2: `ws`=1 only during the last bit of the last slot; 0 otherwise.
- **Stop:** `enable`=0 in RUN -> DRAIN. DRAIN continues normally until the falling edge that would start the next frame, then -> IDLE with all outputs 0 and no `frame_start`.
- **Re-enable in DRAIN:** `enable`=1 during DRAIN -> RUN with no gap and no extra strobe.
- **Reset:** `rst` at any time forces IDLE and all outputs to 0 immediately (asynchronous). A half-finished frame is discarded.

## Timing
- **Latency:** first rising edge `half_div` cycles after the RUN entry cycle.
- **Periods:** SCLK period = 2·half_div cycles. Frame length = 2·half_div·word_bits·channels cycles.
- **Registered outputs:** all outputs are registered, strobes included. Strobes align exactly with the `sclk` transition cycle.
- **half_div=1:** `sclk` toggles every cycle, and rise/fall strobes alternate on consecutive cycles.
- **Final falling edge in DRAIN:** the last falling edge is the IDLE transition. `sclk_fall_stb` is not asserted for it; `sclk` is already low.

## Test plan
- **Reset mid-frame:** assert `rst` during mode 0, ch1 bit 5 -> all outputs 0 the same cycle; stays IDLE after release until `enable`.
- **I2S stereo:** mode 0, half_div=2, word_bits=16 -> SCLK period 4 cycles; `frame_start` every 128 cycles; `ws` rises at the fall beginning ch0 bit 15 and falls at the fall beginning ch1 bit 15.
- **Left-justified:** mode 1, same config -> `ws` toggles coincident with `bit_idx`=0 and `frame_start`.
- **TDM:** mode 2, num_ch_m1=7, word_bits=32, half_div=1 -> frame 512 cycles; `ws` high only for ch7 bit 31 (2 cycles); `chan_idx` counts 0..7.
- **Graceful stop:** drop `enable` at ch0 bit 3 -> clocks continue to frame end, then `busy`=0 and `sclk`=0. Repeat, re-raising `enable` in DRAIN -> continuous frames and no gap.
- **Config handling:** change word_bits 16->24 mid-frame -> takes effect at next `frame_start`. `half_div`=0 behaves as 1. `word_bits`=40 gives 32-bit slots; `word_bits`=4 gives 8-bit slots.

Source files
------------

// File: rtl/i2s_clock_gen.sv
// i2s_clock_gen
//   Timing master for an I2S link. Derives SCLK and WS from clk using a
//   programmable half-period divider. It supports I2S, left-justified and
//   TDM/DSP-A framing. It also exports bit/slot indices and single-cycle edge
//   strobes, so that shifters in the clk domain can run in lock-step with the
//   serial clock.
// Ports
//   clk, rst               system clock, async active-high reset
//   enable                 start / keep generating frames
//   half_div               SCLK half-period in clk cycles (0 acts as 1)
//   word_bits              bits per slot, clamped to 8..32
//   num_ch_m1              TDM slot count - 1 (modes 0/1 are always stereo)
//   mode                   0 I2S, 1 left-justified, 2 TDM, 3 acts as 0
//   sclk, ws               serial clock and word select / frame sync
//   sclk_rise_stb/fall_stb strobes coincident with the sclk transitions
//   frame_start            strobe at slot 0, bit 0
//   chan_idx, bit_idx      current slot and bit (0 = MSB)
//   busy                   high while frames are running or draining
module i2s_clock_gen #(
  parameter int DIV_W  = 8,
  parameter int BITS_W = 6,
  parameter int CH_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DIV_W-1:0]  half_div,
  input  logic [BITS_W-1:0] word_bits,
  input  logic [CH_W-1:0]   num_ch_m1,
  input  logic [1:0]        mode,
  output logic              sclk,
  output logic              ws,
  output logic              sclk_rise_stb,
  output logic              sclk_fall_stb,
  output logic              frame_start,
  output logic [CH_W-1:0]   chan_idx,
  output logic [BITS_W-1:0] bit_idx,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;

  // Sanitised config inputs and their per-frame latched copies
  logic [DIV_W-1:0]  hd_in, hd_q, cnt;
  logic [BITS_W-1:0] wb_in, wb_q, nb;
  logic [CH_W-1:0]   nch_in, nch_q, nc;
  logic [1:0]        md_in, md_q;
  logic              tc, fall_ev, last_bit, frame_end, ws_nx;
  logic              start, stop, load_cfg;

  always_comb begin
    hd_in = (half_div == '0) ? DIV_W'(1) : half_div;
    if (word_bits < BITS_W'(8))       wb_in = BITS_W'(8);
    else if (word_bits > BITS_W'(32)) wb_in = BITS_W'(32);
    else                              wb_in = word_bits;
    md_in  = (mode == 2'd3) ? 2'd0 : mode;
    nch_in = (md_in == 2'd2) ? num_ch_m1 : CH_W'(1);
  end

  always_comb begin
    tc        = (cnt == hd_q - DIV_W'(1));
    fall_ev   = (state != IDLE) && tc && sclk;
    last_bit  = (bit_idx == wb_q - BITS_W'(1));
    frame_end = fall_ev && last_bit && (chan_idx == nch_q);
    nb        = last_bit ? '0 : bit_idx + BITS_W'(1);
    nc        = last_bit ? chan_idx + CH_W'(1) : chan_idx;
    // ws for the bit period that begins on this falling edge. Frame wrap is
    // handled separately, because every mode gives ws=0 on slot 0 bit 0.
    case (md_q)
      2'd1:    ws_nx = nc[0];
      2'd2:    ws_nx = (nb == wb_q - BITS_W'(1)) && (nc == nch_q);
      default: ws_nx = (nb == wb_q - BITS_W'(1)) ? ~nc[0] : nc[0]; // I2S leads by one bit
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = RUN;
      RUN:     if (!enable) state_nx = DRAIN;
      DRAIN:   if (enable) state_nx = RUN;
               else if (frame_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign start    = (state == IDLE) && enable;
  assign stop     = (state != IDLE) && (state_nx == IDLE);
  assign load_cfg = start || (frame_end && !stop);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hd_q  <= DIV_W'(1);
      wb_q  <= BITS_W'(8);
      nch_q <= CH_W'(1);
      md_q  <= 2'd0;
    end else if (load_cfg) begin
      hd_q  <= hd_in;
      wb_q  <= wb_in;
      nch_q <= nch_in;
      md_q  <= md_in;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0; sclk <= 1'b0; ws <= 1'b0; busy <= 1'b0;
      sclk_rise_stb <= 1'b0; sclk_fall_stb <= 1'b0; frame_start <= 1'b0;
      chan_idx <= '0; bit_idx <= '0;
    end else begin
      sclk_rise_stb <= 1'b0;
      sclk_fall_stb <= 1'b0;
      frame_start   <= 1'b0;
      busy          <= (state_nx != IDLE);
      if (state == IDLE) begin
        if (start) begin
          cnt <= '0; sclk <= 1'b0; ws <= 1'b0;
          chan_idx <= '0; bit_idx <= '0;
          frame_start <= 1'b1;
        end
      end else if (stop) begin
        // The final falling edge is the return to idle. It raises no strobe.
        cnt <= '0; sclk <= 1'b0; ws <= 1'b0;
        chan_idx <= '0; bit_idx <= '0;
      end else if (tc) begin
        cnt  <= '0;
        sclk <= ~sclk;
        if (!sclk) sclk_rise_stb <= 1'b1;
        else begin
          sclk_fall_stb <= 1'b1;
          if (frame_end) begin
            chan_idx <= '0; bit_idx <= '0; ws <= 1'b0;
            frame_start <= 1'b1;
          end else begin
            chan_idx <= nc; bit_idx <= nb; ws <= ws_nx;
          end
        end
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end

endmodule

// File: tb/tb_i2s_clock_gen.sv
// Testbench for i2s_clock_gen. A reference model tracks the position inside
// the current frame as an elapsed cycle count. It then derives every output
// arithmetically from that count and the config latched for the frame.
module tb_i2s_clock_gen;
  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [7:0] half_div = 8'd2;
  logic [5:0] word_bits = 6'd16;
  logic [2:0] num_ch_m1 = 3'd0;
  logic [1:0] mode = 2'd0;
  logic       sclk, ws, sclk_rise_stb, sclk_fall_stb, frame_start, busy;
  logic [2:0] chan_idx;
  logic [5:0] bit_idx;

  i2s_clock_gen #(.DIV_W(8), .BITS_W(6), .CH_W(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .half_div(half_div),
    .word_bits(word_bits), .num_ch_m1(num_ch_m1), .mode(mode),
    .sclk(sclk), .ws(ws), .sclk_rise_stb(sclk_rise_stb),
    .sclk_fall_stb(sclk_fall_stb), .frame_start(frame_start),
    .chan_idx(chan_idx), .bit_idx(bit_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int cyc_n = 0, fs_last = -1, fs_exp = 0;

  // Reference model state: active / draining flags, the cycle offset into
  // the frame, whether this frame came straight from idle, and latched config
  bit m_act = 0, m_drain = 0, m_first = 0;
  int m_t = 0, m_hd = 1, m_wb = 8, m_nc = 2, m_md = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic latch_cfg();
    m_hd = (half_div == 0) ? 1 : int'(half_div);
    m_wb = (word_bits < 8) ? 8 : (word_bits > 32) ? 32 : int'(word_bits);
    m_md = (mode == 2'd3) ? 0 : int'(mode);
    m_nc = (m_md == 2) ? int'(num_ch_m1) + 1 : 2;
  endtask

  // Advances the model over one rising clk edge, using the inputs held now
  task automatic step();
    int flen;
    if (rst) begin
      m_act = 0;
    end else if (!m_act) begin
      if (enable) begin
        m_act = 1; m_drain = 0; m_t = 0; m_first = 1;
        latch_cfg();
      end
    end else begin
      flen = 2 * m_hd * m_wb * m_nc;
      if (m_t + 1 == flen) begin
        if (m_drain && !enable) m_act = 0;
        else begin m_t = 0; m_first = 0; latch_cfg(); end
      end else m_t++;
      m_drain = !enable;
    end
  endtask

  function automatic int cur_p();
    return m_t / (2 * m_hd);
  endfunction

  task automatic compare(string tag);
    logic e_sclk, e_ws, e_rise, e_fall, e_fs, e_busy;
    int   e_bit, e_ch, h, p;
    bit   ph;
    e_sclk = 0; e_ws = 0; e_rise = 0; e_fall = 0; e_fs = 0; e_busy = 0;
    e_bit = 0; e_ch = 0;
    if (m_act) begin
      h  = m_t / m_hd;
      p  = cur_p();
      ph = (m_t % m_hd) == 0;
      e_sclk = h[0];
      e_rise = ph && h[0];
      e_fall = ph && !h[0] && !(m_t == 0 && m_first);
      e_bit  = p % m_wb;
      e_ch   = p / m_wb;
      e_fs   = (m_t == 0);
      e_busy = 1;
      case (m_md)
        1:       e_ws = e_ch[0];
        2:       e_ws = (e_bit == m_wb - 1) && (e_ch == m_nc - 1);
        default: e_ws = (((p + 1) / m_wb) % 2) == 1;  // channel of the next bit
      endcase
    end
    chk({tag, " sclk"}, 32'(sclk), 32'(e_sclk));
    chk({tag, " ws"}, 32'(ws), 32'(e_ws));
    chk({tag, " rise_stb"}, 32'(sclk_rise_stb), 32'(e_rise));
    chk({tag, " fall_stb"}, 32'(sclk_fall_stb), 32'(e_fall));
    chk({tag, " frame_start"}, 32'(frame_start), 32'(e_fs));
    chk({tag, " bit_idx"}, 32'(bit_idx), e_bit);
    chk({tag, " chan_idx"}, 32'(chan_idx), e_ch);
    chk({tag, " busy"}, 32'(busy), 32'(e_busy));
  endtask

  task automatic cyc(string tag);
    step();
    @(negedge clk);
    cyc_n++;
    compare(tag);
    if (fs_exp != 0 && frame_start === 1'b1) begin
      if (fs_last >= 0) chk({tag, " fs_period"}, cyc_n - fs_last, fs_exp);
      fs_last = cyc_n;
    end
  endtask

  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic set_cfg(int hd, int wb, int nch, int md);
    half_div = 8'(hd); word_bits = 6'(wb); num_ch_m1 = 3'(nch); mode = 2'(md);
  endtask

  // Runs until the model sits at the first cycle of slot ch, bit bt
  task automatic wait_pos(string tag, int ch, int bt);
    bit hit;
    hit = 0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      if (m_act && (m_t % (2 * m_hd)) == 0 && cur_p() / m_wb == ch && cur_p() % m_wb == bt)
        hit = 1;
      else cyc(tag);
    end
    if (!hit) chk({tag, " reach_pos"}, 0, 1);
  endtask

  task automatic wait_idle(string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      if (!m_act) hit = 1;
      else cyc(tag);
    end
    if (!hit) chk({tag, " reach_idle"}, 0, 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    compare("reset");
    rst = 1'b0;
    run("idle", 5);

    // I2S stereo: 128-cycle frames
    set_cfg(2, 16, 0, 0); enable = 1'b1;
    fs_exp = 128; fs_last = -1;
    run("i2s", 400);

    // Asynchronous reset in the middle of ch1 bit 5
    fs_exp = 0;
    wait_pos("i2s_pos", 1, 5);
    rst = 1'b1; #1;
    m_act = 0;
    compare("rst_async");
    @(negedge clk);
    rst = 1'b0; enable = 1'b0;
    run("rst_idle", 10);

    // Left-justified
    set_cfg(2, 16, 0, 1); enable = 1'b1;
    fs_exp = 128; fs_last = -1;
    run("lj", 300);

    // TDM 8x32, half_div=1: 512-cycle frames, switched at a frame boundary
    set_cfg(1, 32, 7, 2);
    fs_exp = 512; fs_last = -1;
    run("tdm", 1200);

    // Graceful stop from ch0 bit 3
    fs_exp = 0;
    set_cfg(2, 16, 0, 0);
    wait_pos("stop_pos", 0, 3);
    enable = 1'b0;
    wait_idle("drain");
    run("stopped", 10);

    // Re-enable while draining: no gap between frames
    enable = 1'b1;
    fs_exp = 128; fs_last = -1;
    wait_pos("redrain_pos", 0, 3);
    enable = 1'b0;
    run("drain", 50);
    enable = 1'b1;
    run("redrain", 300);

    // Mid-frame word length change takes effect at the next frame
    wait_pos("cfg_pos", 0, 3);
    word_bits = 6'd24;
    fs_exp = 192; fs_last = -1;
    run("wb24", 500);
    half_div = 8'd0; word_bits = 6'd16;
    fs_exp = 64; fs_last = -1;
    run("hd0", 250);
    word_bits = 6'd40;
    fs_exp = 128; fs_last = -1;
    run("wb40", 400);
    word_bits = 6'd4;
    fs_exp = 32; fs_last = -1;
    run("wb4", 150);
    fs_exp = 0;

    // Randomised configs, enable toggles and mid-frame config jitter
    for (int s = 0; s < 12; s++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 7),
              $urandom_range(0, 3));
      enable = 1'b1;
      for (int i = 0; i < int'($urandom_range(200, 1500)); i++) begin
        if ($urandom_range(0, 99) < 2) enable = ~enable;
        if ($urandom_range(0, 99) < 5)
          case ($urandom_range(0, 3))
            0: half_div  = 8'($urandom_range(0, 3));
            1: word_bits = 6'($urandom_range(0, 63));
            2: num_ch_m1 = 3'($urandom_range(0, 7));
            default: mode = 2'($urandom_range(0, 3));
          endcase
        cyc("rand");
      end
    end
    enable = 1'b0;
    wait_idle("final");
    run("final_idle", 5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
